reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer flop depth for isLocked; legal values are 2 or more.
REQ-002 Parameter LOCK_STABLE_CYCLES, default 1024: consecutive lockSync-high cycles required before reset hold begins; legal values are 1 or more.
REQ-003 Parameter RESET_HOLD_CYCLES, default 16: cycles coreReset stays asserted after lock is qualified; legal values are 1 or more.
REQ-004 Port clk, input, 1: single clock, driven by the PLL output clock; all logic runs on its rising edge.
REQ-005 Port resetN, input, 1: synchronous, active-low reset.
REQ-006 Port isLocked, input, 1: PLL lock indicator, asynchronous to clk.
REQ-007 Port softReset, input, 1: synchronous request to re-run the reset hold.
REQ-008 Port coreReset, output, 1: registered active-high reset for the CPU core domain.
REQ-009 Port coreResetN, output, 1: registered, always the inverse of coreReset.
REQ-010 Port isReady, output, 1: registered, high exactly when state is RUN.
REQ-011 Port lockLossCount, output, 8: count of lock losses, saturating.

Function
REQ-012 The block SHALL pass isLocked through a SYNC_STAGES-deep flop chain; lockSync is the last flop, and no other logic samples isLocked.
REQ-013 The FSM SHALL have exactly four states: WAIT_LOCK, STABILIZE, HOLD_RESET, RUN.
REQ-014 A single counter cnt SHALL be shared by STABILIZE and HOLD_RESET; its width is clog2(max(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES)+1).
REQ-015 WAIT_LOCK: when lockSync=1, go to STABILIZE with cnt=0; otherwise stay.
REQ-016 STABILIZE, lockSync=0: go to WAIT_LOCK.
REQ-017 STABILIZE, lockSync=1 and cnt=LOCK_STABLE_CYCLES-1: go to HOLD_RESET with cnt=0.
REQ-018 STABILIZE, lockSync=1 otherwise: increment cnt.
REQ-019 HOLD_RESET, lockSync=0: go to WAIT_LOCK.
REQ-020 HOLD_RESET, cnt=RESET_HOLD_CYCLES-1: go to RUN.
REQ-021 HOLD_RESET otherwise: increment cnt.
REQ-022 RUN, lockSync=0: go to WAIT_LOCK.
REQ-023 RUN, lockSync=1 and softReset=1: go to HOLD_RESET with cnt=0.
REQ-024 softReset SHALL be ignored in WAIT_LOCK, STABILIZE and HOLD_RESET.
REQ-025 Lock loss (lockSync=0) SHALL take priority over softReset and over counter completion in the same cycle.
REQ-026 coreReset, coreResetN and isReady SHALL be registered from the next-state value, so they change on the same edge as the state register.
REQ-027 coreReset=1 in every state except RUN.
REQ-028 Latency: with isLocked steady high from edge 1 and never dropping, coreReset falls at edge SYNC_STAGES+1+LOCK_STABLE_CYCLES+RESET_HOLD_CYCLES, which is 1043 with default parameters.
REQ-029 Latency: an isLocked fall in RUN SHALL assert coreReset at edge SYNC_STAGES+1 after the first edge that samples isLocked=0.
REQ-030 lockLossCount SHALL increment by 1 on every transition to WAIT_LOCK caused by lockSync=0 from STABILIZE, HOLD_RESET or RUN.
REQ-031 lockLossCount SHALL saturate at 255 and never wrap.
REQ-032 A glitch on isLocked shorter than one clk period SHALL cause either no effect or a full restart from WAIT_LOCK, never a partial count.

Reset
REQ-033 While resetN=0 at a rising edge, the block SHALL set all synchronizer flops to 0, state to WAIT_LOCK, cnt to 0 and lockLossCount to 0.
REQ-034 While resetN=0 at a rising edge, the outputs SHALL be coreReset=1, coreResetN=0 and isReady=0.
REQ-035 resetN SHALL override every other input.
REQ-036 resetN asserted mid-sequence SHALL abort the sequence; after release the full sequence restarts from WAIT_LOCK.

Verification (SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=4)
REQ-037 Power-up: release resetN, then drive isLocked=1 from edge 1 -> coreReset falls and isReady rises exactly at edge 15; lockLossCount=0.
REQ-038 Unstable lock: isLocked high for 5 edges, low for 1, then high again -> no deassert at edge 15; lockLossCount=1; deassert occurs 15 edges after the re-rise.
REQ-039 Lock loss in RUN: drop isLocked for 3 cycles -> coreReset=1 at edge 3 after the drop; lockLossCount increments by 1; full 15-edge re-sequence follows.
REQ-040 softReset: 1-cycle pulse in RUN -> coreReset=1 on the next edge for exactly 4 cycles, then RUN; lockLossCount unchanged.
REQ-041 Priority and saturation: softReset=1 and lockSync=0 in the same RUN cycle -> state WAIT_LOCK; 300 forced lock losses -> lockLossCount=255.
REQ-042 Reset mid-HOLD_RESET: resetN=0 for 1 cycle -> coreReset=1 and lockLossCount=0; release with isLocked=1 -> deassert 15 edges later.

Source files
------------

// File: rtl/reset_sequencer.sv
// PLL-lock driven reset sequencer: synchronizes isLocked, qualifies a stable lock,
// holds the core in reset for a fixed window, then releases it; counts lock losses.
module reset_sequencer #(
   parameter int SYNC_STAGES        = 2,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int RESET_HOLD_CYCLES  = 16
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       isLocked,
   input  logic       softReset,
   output logic       coreReset,
   output logic       coreResetN,
   output logic       isReady,
   output logic [7:0] lockLossCount,
   // Debug view of the FSM: 0=WAIT_LOCK, 1=STABILIZE, 2=HOLD_RESET, 3=RUN.
   output logic [1:0] state_dbg
);

   localparam int MAX_CYCLES = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                               LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_CYCLES);

   typedef enum logic [1:0] {
      WAIT_LOCK  = 2'd0,
      STABILIZE  = 2'd1,
      HOLD_RESET = 2'd2,
      RUN        = 2'd3
   } state_e;

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [7:0]             loss_cnt_q, loss_cnt_d;
   logic                   core_reset_q, core_reset_d;
   logic                   core_reset_n_q, core_reset_n_d;
   logic                   is_ready_q, is_ready_d;
   logic                   lock_sync;
   logic                   lock_lost;

   // Only the first flop of this chain ever sees the asynchronous isLocked.
   assign lock_sync = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d    = {sync_q[SYNC_STAGES-2:0], isLocked};
      state_d   = state_q;
      cnt_d     = cnt_q;
      lock_lost = 1'b0;

      // Lock loss is tested first in every locked state so it wins over
      // counter completion and over softReset.
      case (state_q)
         WAIT_LOCK: begin
            if (lock_sync) begin
               state_d = STABILIZE;
               cnt_d   = '0;
            end
         end
         STABILIZE: begin
            if (!lock_sync) begin
               state_d   = WAIT_LOCK;
               lock_lost = 1'b1;
            end else if (cnt_q == STAB_LAST) begin
               state_d = HOLD_RESET;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HOLD_RESET: begin
            if (!lock_sync) begin
               state_d   = WAIT_LOCK;
               lock_lost = 1'b1;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RUN: begin
            if (!lock_sync) begin
               state_d   = WAIT_LOCK;
               lock_lost = 1'b1;
            end else if (softReset) begin
               state_d = HOLD_RESET;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
         end
      endcase

      loss_cnt_d = loss_cnt_q;
      if (lock_lost && (loss_cnt_q != 8'hFF)) begin
         loss_cnt_d = loss_cnt_q + 8'd1;
      end

      // Outputs follow the next state so they move on the same edge as state_q.
      core_reset_d   = (state_d != RUN);
      core_reset_n_d = (state_d == RUN);
      is_ready_d     = (state_d == RUN);
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         sync_q         <= '0;
         state_q        <= WAIT_LOCK;
         cnt_q          <= '0;
         loss_cnt_q     <= '0;
         core_reset_q   <= 1'b1;
         core_reset_n_q <= 1'b0;
         is_ready_q     <= 1'b0;
      end else begin
         sync_q         <= sync_d;
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         loss_cnt_q     <= loss_cnt_d;
         core_reset_q   <= core_reset_d;
         core_reset_n_q <= core_reset_n_d;
         is_ready_q     <= is_ready_d;
      end
   end

   assign coreReset     = core_reset_q;
   assign coreResetN    = core_reset_n_q;
   assign isReady       = is_ready_q;
   assign lockLossCount = loss_cnt_q;
   assign state_dbg     = state_q;

   a_reset_pair : assert property (@(posedge clk) disable iff (!resetN)
      coreResetN == !coreReset);
   a_ready_run : assert property (@(posedge clk) disable iff (!resetN)
      isReady == (state_q == RUN));
   a_cnt_range : assert property (@(posedge clk) disable iff (!resetN)
      cnt_q < CNT_LIMIT);

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized + directed bench for reset_sequencer; a "remaining high samples"
// reference model feeds an expected queue that a monitor drains every cycle.
module tb_reset_sequencer;

  localparam int S = 2;
  localparam int L = 8;
  localparam int H = 4;
  localparam int SEQ_EDGES = S + 1 + L + H;
  localparam logic [1:0] WAIT_LOCK_ENC = 2'd0;

  logic       clk = 1'b0;
  logic       resetN;
  logic       isLocked;
  logic       softReset;
  logic       coreReset;
  logic       coreResetN;
  logic       isReady;
  logic [7:0] lockLossCount;
  logic [1:0] state_dbg;

  int total = 0;
  int bad = 0;

  // Expected {coreReset, coreResetN, isReady, lockLossCount} after each edge.
  logic [10:0] exp_q[$];

  // Reference model state.
  logic [S-1:0] m_sync;
  int           m_need;
  bit           m_wait;
  bit           m_ready;
  int           m_loss;

  // Clock / reset block.
  always #5 clk = ~clk;

  reset_sequencer #(
    .SYNC_STAGES(S),
    .LOCK_STABLE_CYCLES(L),
    .RESET_HOLD_CYCLES(H)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .isLocked(isLocked),
    .softReset(softReset),
    .coreReset(coreReset),
    .coreResetN(coreResetN),
    .isReady(isReady),
    .lockLossCount(lockLossCount),
    .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the core is released once enough consecutive high lockSync samples
  // have been seen (L+H+1 from a fresh start, H after a soft reset).
  task automatic model_step(input logic r, input logic l, input logic s);
    logic ls;
    if (!r) begin
      m_sync  = '0;
      m_need  = L + H + 1;
      m_wait  = 1'b1;
      m_ready = 1'b0;
      m_loss  = 0;
    end else begin
      ls     = m_sync[S-1];
      m_sync = {m_sync[S-2:0], l};
      if (!ls) begin
        if (!m_wait && m_loss < 255) m_loss++;
        m_wait  = 1'b1;
        m_need  = L + H + 1;
        m_ready = 1'b0;
      end else begin
        m_wait = 1'b0;
        if (m_ready && s) begin
          m_need  = H;
          m_ready = 1'b0;
        end else begin
          if (m_need > 0) m_need--;
          m_ready = (m_need == 0);
        end
      end
    end
    exp_q.push_back({~m_ready, m_ready, m_ready, 8'(m_loss)});
  endtask

  // Driver: one call per clock, inputs change on the falling edge.
  task automatic drive_cycle(input logic r, input logic l, input logic s);
    @(negedge clk);
    resetN    = r;
    isLocked  = l;
    softReset = s;
    model_step(r, l, s);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // Counts edges (first edge = 1) with lock held high until isReady rises.
  task automatic edges_until_ready(input int limit, output int n);
    n = limit;
    for (int i = 1; i <= limit; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0);
      settle();
      if (isReady === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Scoreboard monitor.
  initial begin
    logic [10:0] e;
    logic [10:0] a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {coreReset, coreResetN, isReady, lockLossCount};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs: got rst=%b rstn=%b rdy=%b loss=%0d expected rst=%b rstn=%b rdy=%b loss=%0d (t=%0t)",
                   a[10], a[9], a[8], a[7:0], e[10], e[9], e[8], e[7:0], $time);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int drop_edge;
    bit lk;

    resetN    = 1'b0;
    isLocked  = 1'b0;
    softReset = 1'b0;

    // Reset state.
    repeat (3) drive_cycle(1'b0, 1'b0, 1'b0);
    settle();
    check("reset_core_reset", coreReset, 1);
    check("reset_core_reset_n", coreResetN, 0);
    check("reset_ready", isReady, 0);
    check("reset_loss", lockLossCount, 0);
    check("reset_state", state_dbg, WAIT_LOCK_ENC);

    // Power-up latency.
    edges_until_ready(100, n);
    check("powerup_latency", n, SEQ_EDGES);
    check("powerup_loss", lockLossCount, 0);
    repeat (5) drive_cycle(1'b1, 1'b1, 1'b0);

    // Unstable lock: 5 high, 1 low, then high again.
    repeat (2) drive_cycle(1'b0, 1'b0, 1'b0);
    repeat (5) drive_cycle(1'b1, 1'b1, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0);
    edges_until_ready(100, n);
    check("unstable_relock_latency", n, SEQ_EDGES);
    check("unstable_loss", lockLossCount, 1);

    // Lock loss while running.
    drop_edge = 0;
    for (int i = 1; i <= 3; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0);
      settle();
      if (drop_edge == 0 && coreReset === 1'b1) drop_edge = i;
    end
    check("lockloss_latency", drop_edge, S + 1);
    check("lockloss_count", lockLossCount, 2);
    edges_until_ready(100, n);
    check("lockloss_resequence", n, SEQ_EDGES);

    // Soft reset pulse.
    drive_cycle(1'b1, 1'b1, 1'b1);
    settle();
    check("soft_assert", coreReset, 1);
    edges_until_ready(100, n);
    check("soft_hold_len", n, H);
    check("soft_loss", lockLossCount, 2);

    // softReset coinciding with lockSync=0 in RUN.
    drive_cycle(1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b1);
    settle();
    check("prio_state", state_dbg, WAIT_LOCK_ENC);
    check("prio_loss", lockLossCount, 3);

    // Saturation.
    repeat (300) begin
      drive_cycle(1'b1, 1'b1, 1'b0);
      drive_cycle(1'b1, 1'b0, 1'b0);
    end
    repeat (4) drive_cycle(1'b1, 1'b0, 1'b0);
    settle();
    check("saturate_loss", lockLossCount, 255);

    // Reset in the middle of HOLD_RESET.
    repeat (S + 1 + L + 1) drive_cycle(1'b1, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b1, 1'b0);
    settle();
    check("midhold_core_reset", coreReset, 1);
    check("midhold_loss", lockLossCount, 0);
    edges_until_ready(100, n);
    check("midhold_resequence", n, SEQ_EDGES);

    // Randomized traffic.
    lk = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 39) == 0) lk = ~lk;
      drive_cycle($urandom_range(0, 299) != 0, lk ^ ($urandom_range(0, 99) == 0),
                  $urandom_range(0, 15) == 0);
    end

    settle();
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
